// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if - byte-strobe ingress bundle for the UART transmitter.
// The upstream stage (master) drives a one-cycle strobe with its byte, and
// observes the FIFO-full level and the sticky overflow flag returned by the
// transmitter (slave).
interface uart_tx_fifo_if;
  logic       i_data_avail;
  logic [7:0] i_data_byte;
  logic       o_fifo_full;
  logic       o_overflow;

  modport master (
    output i_data_avail,
    output i_data_byte,
    input  o_fifo_full,
    input  o_overflow
  );

  modport slave (
    input  i_data_avail,
    input  i_data_byte,
    output o_fifo_full,
    output o_overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo - byte FIFO feeding an 8N1 UART serializer.
// Bytes arrive as single-cycle strobes on the interface and queue in a
// FIFO_DEPTH-entry buffer. The FSM pops one byte per frame and drives the
// TX pin. The pin, the active flag and the done pulse are all registered,
// so the line lags the FSM state by one clock.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between
// the last data bit and the stop bit (11-bit frame).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | line high; pops the FIFO head when one is present
// START   | start bit (low) for one bit time
// DATA    | data bits 0..7, LSB first, one bit time each
// PARITY  | even parity of the data byte (UART_TX_PARITY_EN only)
// STOP    | stop bit (high); done pulse on its final clock
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  uart_tx_fifo_if.slave   bus,
  output logic            o_tx_serial,
  output logic            o_tx_active,
  output logic            o_tx_done
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FILL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic              pop;

  // serializer
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              bit_end;

  // registered pin-side outputs
  logic              tx_serial_q, tx_serial_d;
  logic              tx_active_q, tx_active_d;
  logic              tx_done_q, tx_done_d;

  assign fifo_full  = (fill_q == FILL_FULL);
  assign fifo_empty = (fill_q == '0);
  assign bit_end    = (bit_cnt_q == BIT_LAST);

  assign bus.o_fifo_full = fifo_full;
  assign bus.o_overflow  = overflow_q;
  assign o_tx_serial     = tx_serial_q;
  assign o_tx_active     = tx_active_q;
  assign o_tx_done       = tx_done_q;

  // FIFO next-state: the full check uses the registered level, so a pop on
  // the same edge never makes room for a strobe that arrived while full.
  always_comb begin
    wr_en      = bus.i_data_avail && !fifo_full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q | (bus.i_data_avail & fifo_full);
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // FIFO data array; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.i_data_byte;
    end
  end

  // FIFO pointer, fill level and sticky overflow registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // FSM next-state: bit-time counter, bit index, shift register and pop
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // pin-side outputs decoded from the current state, then registered
  always_comb begin
    tx_serial_d = 1'b1;
    tx_active_d = (state_q != ST_IDLE);
    tx_done_d   = (state_q == ST_STOP) && bit_end;
    case (state_q)
      ST_START:  tx_serial_d = 1'b0;
      ST_DATA:   tx_serial_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_serial_d = ^shift_q;
`endif
      default:   tx_serial_d = 1'b1;
    endcase
  end

  // FSM and output registers; reset forces the line high at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo - randomized and directed bench for uart_tx_fifo.
// The reference model treats the transmitter as a single server: each
// accepted byte gets a pop time (one clock after arrival, or one clock after
// the previous frame's FSM completes), and the expected pin level of every
// clock is derived from the list of scheduled frames.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FLEN  = FBITS * CPB;

  logic clock = 1'b0;
  logic reset_n;
  logic o_tx_serial;
  logic o_tx_active;
  logic o_tx_done;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_tx_serial (o_tx_serial),
    .o_tx_active (o_tx_active),
    .o_tx_done   (o_tx_done)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         t        = 0;
  int         fr_pop[$];
  logic [7:0] fr_byte[$];
  logic       model_ovf = 1'b0;
  int         last_pop  = -100000;
  int         n_done    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // bytes accepted before edge e that are still in the FIFO just before e
  function automatic int queued_before(input int e);
    int n = 0;
    foreach (fr_pop[i]) if (fr_pop[i] >= e) n++;
    return n;
  endfunction

  function automatic int queued_after(input int e);
    int n = 0;
    foreach (fr_pop[i]) if (fr_pop[i] > e) n++;
    return n;
  endfunction

  task automatic model_strobe(input int e, input logic [7:0] b);
    int p;
    if (queued_before(e) >= DEPTH) begin
      model_ovf = 1'b1;
    end else begin
      p = e + 1;
      if (last_pop + FLEN + 1 > p) p = last_pop + FLEN + 1;
      fr_pop.push_back(p);
      fr_byte.push_back(b);
      last_pop = p;
    end
  endtask

  task automatic model_reset();
    fr_pop.delete();
    fr_byte.delete();
    model_ovf = 1'b0;
    last_pop  = -100000;
  endtask

  task automatic check_outputs(input int e);
    logic       exp_line = 1'b1;
    logic       exp_act  = 1'b0;
    logic       exp_done = 1'b0;
    logic [7:0] b;
    int         s;
    int         k;
    foreach (fr_pop[i]) begin
      s = fr_pop[i] + 1;
      if (e >= s && e < s + FLEN) begin
        b       = fr_byte[i];
        k       = (e - s) / CPB;
        exp_act = 1'b1;
        if (k == 0)                     exp_line = 1'b0;
        else if (k <= 8)                exp_line = b[k-1];
        else if (k == 9 && FBITS == 11) exp_line = ^b;
        else                            exp_line = 1'b1;
        exp_done = (e == s + FLEN - 1);
      end
    end
    check_val("tx_serial", {31'd0, o_tx_serial}, {31'd0, exp_line});
    check_val("tx_active", {31'd0, o_tx_active}, {31'd0, exp_act});
    check_val("tx_done", {31'd0, o_tx_done}, {31'd0, exp_done});
    check_val("fifo_full", {31'd0, bus.o_fifo_full}, {31'd0, (queued_after(e) == DEPTH)});
    check_val("overflow", {31'd0, bus.o_overflow}, {31'd0, model_ovf});
    if (o_tx_done === 1'b1) n_done++;
  endtask

  task automatic tick(input logic av, input logic [7:0] by);
    bus.i_data_avail = av;
    bus.i_data_byte  = by;
    @(posedge clock);
    t++;
    if (av) model_strobe(t, by);
    @(negedge clock);
    check_outputs(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  // asynchronous reset between edges; outputs must settle with no clock
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_serial", {31'd0, o_tx_serial}, 32'd1);
    check_val("rst_active", {31'd0, o_tx_active}, 32'd0);
    check_val("rst_done", {31'd0, o_tx_done}, 32'd0);
    check_val("rst_full", {31'd0, bus.o_fifo_full}, 32'd0);
    check_val("rst_overflow", {31'd0, bus.o_overflow}, 32'd0);
    model_reset();
    @(posedge clock);
    t++;
    @(negedge clock);
    check_outputs(t);
    reset_n = 1'b1;
  endtask

  int rates[6] = '{2, 10, 40, 90, 5, 60};
  int done_before;

  initial begin
    bus.i_data_avail = 1'b0;
    bus.i_data_byte  = 8'h00;
    reset_n          = 1'b1;
    @(negedge clock);
    async_reset();

    // long idle: line stays high, no done pulse
    idle(1000);
    check_val("idle_done_count", n_done, 0);

    // single byte, then the three-byte back-to-back burst
    tick(1'b1, 8'h55);
    idle(FLEN + 10);
    check_val("single_done_count", n_done, 1);
    tick(1'b1, 8'hA3);
    tick(1'b1, 8'h00);
    tick(1'b1, 8'hFF);
    idle(3 * (FLEN + 1) + 10);
    check_val("burst_done_count", n_done, 4);

    // parity-sensitive bytes (plain 8N1 frames in the default build)
    tick(1'b1, 8'h07);
    idle(FLEN + 5);
    tick(1'b1, 8'h03);
    idle(FLEN + 5);

    // six strobes into a four-entry FIFO: the sixth is dropped
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
    idle(5 * (FLEN + 1) + 10);
    check_val("ovf_sticky", {31'd0, bus.o_overflow}, 32'd1);

    // reset mid-DATA with a second byte still queued
    async_reset();
    done_before = n_done;
    tick(1'b1, 8'h0F);
    tick(1'b1, 8'h33);
    idle(3 * CPB);
    async_reset();
    idle(3 * FLEN);
    check_val("post_reset_quiet", n_done, done_before);

    // randomized traffic at several strobe densities
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 250; i++) begin
        tick(($urandom_range(0, 99) < rates[blk]) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)));
      end
      if (blk == 2) async_reset();
    end
    idle((DEPTH + 1) * (FLEN + 1) + 10);
    check_val("drained_active", {31'd0, o_tx_active}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
